alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the datapath's 16-bit combinational ALU.
- WIDTH-bit operands, same 5-bit function-select style and {V,C,N,Z} status vector.
- Adds iterative shifts, unsigned multiply, divide and remainder, behind a start/busy/done handshake.
- Sits between the register file read ports and the writeback mux. The control unit stalls on busy.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq_logic.sv | 58 +++++
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_defs: function codes, FSM states and status bit positions
// shared by the sequential ALU and its combinational slice.
package alu_defs;

  localparam logic [4:0] FS_PASS_A = 5'h00;
  localparam logic [4:0] FS_INC    = 5'h01;
  localparam logic [4:0] FS_ADD    = 5'h02;
  localparam logic [4:0] FS_SUB    = 5'h05;
  localparam logic [4:0] FS_DEC    = 5'h06;
  localparam logic [4:0] FS_AND    = 5'h08;
  localparam logic [4:0] FS_OR     = 5'h09;
  localparam logic [4:0] FS_XOR    = 5'h0A;
  localparam logic [4:0] FS_NOT_A  = 5'h0B;
  localparam logic [4:0] FS_PASS_B = 5'h0C;
  localparam logic [4:0] FS_SHL    = 5'h10;
  localparam logic [4:0] FS_SHR    = 5'h11;
  localparam logic [4:0] FS_SAR    = 5'h12;
  localparam logic [4:0] FS_MUL    = 5'h18;
  localparam logic [4:0] FS_DIVU   = 5'h19;
  localparam logic [4:0] FS_REMU   = 5'h1A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MUL,
    S_DIV
  } state_t;

  localparam int ST_V = 3;
  localparam int ST_C = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  function automatic logic is_shift(input logic [4:0] fs);
    return (fs == FS_SHL) || (fs == FS_SHR) || (fs == FS_SAR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done request bundle for the sequential ALU.
// master drives start/FS/A/B; slave returns F/status/busy/done.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [4:0]       FS;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] F;
  logic [3:0]       status;
  logic             busy;
  logic             done;

  modport master (
    output start, FS, A, B,
    input  F, status, busy, done
  );

  modport slave (
    input  start, FS, A, B,
    output F, status, busy, done
  );
endinterface

// File: rtl/alu_seq_logic.sv
// alu_seq_logic: single-cycle arith/logic/pass result with V and C.
// Ports: fs, a, b in; f, v, c out. Shift codes return a unchanged.
module alu_seq_logic
  import alu_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [4:0]       fs,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f,
  output logic             v,
  output logic             c
);

  logic [WIDTH-1:0] y;
  logic             cin;
  logic             arith;
  logic [WIDTH:0]   sum;

  always_comb begin
    y     = '0;
    cin   = 1'b0;
    arith = 1'b1;
    // all four arith ops share one adder: a + y + cin
    case (fs)
      FS_ADD:  y = b;
      FS_INC:  cin = 1'b1;
      FS_SUB:  begin y = ~b; cin = 1'b1; end
      FS_DEC:  y = '1;
      default: arith = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    f = '0;
    v = 1'b0;
    c = 1'b0;
    if (arith) begin
      f = sum[WIDTH-1:0];
      c = sum[WIDTH];
      v = (a[WIDTH-1] == y[WIDTH-1]) &&
          (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      case (fs)
        FS_AND:    f = a & b;
        FS_OR:     f = a | b;
        FS_XOR:    f = a ^ b;
        FS_NOT_A:  f = ~a;
        FS_PASS_B: f = b;
        FS_PASS_A,
        FS_SHL,
        FS_SHR,
        FS_SAR:    f = a;
        default:   f = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU (shift, mul, div/rem) with start/busy/done.
// Ports: clock, reset (sync, active-high), bus (alu_seq_if.slave).
module alu_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 16
) (
  input logic      clock,
  input logic      reset,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  state_t           state;
  logic [4:0]       fs_q;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] f_q;
  logic [3:0]       st_q;
  logic             busy_q;
  logic             done_q;

  assign bus.F      = f_q;
  assign bus.status = st_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  logic [WIDTH-1:0] lf;
  logic             lv;
  logic             lc;

  alu_seq_logic #(.WIDTH(WIDTH)) u_logic (
    .fs (bus.FS),
    .a  (bus.A),
    .b  (bus.B),
    .f  (lf),
    .v  (lv),
    .c  (lc)
  );

  logic [SHW-1:0] amt;
  logic           go_shift;
  logic           go_mul;
  logic           go_div;

  assign amt      = bus.B[SHW-1:0];
  assign go_shift = is_shift(bus.FS) && (amt != '0);
  assign go_mul   = bus.FS == FS_MUL;
  assign go_div   = (bus.FS == FS_DIVU) || (bus.FS == FS_REMU);

  // shift: one bit per step, sh_out is the bit leaving this step
  logic [WIDTH-1:0] sh_n;
  logic             sh_out;

  always_comb begin
    if (fs_q == FS_SHL) begin
      sh_n   = {opa[WIDTH-2:0], 1'b0};
      sh_out = opa[WIDTH-1];
    end else if (fs_q == FS_SHR) begin
      sh_n   = {1'b0, opa[WIDTH-1:1]};
      sh_out = opa[0];
    end else begin
      sh_n   = {opa[WIDTH-1], opa[WIDTH-1:1]};
      sh_out = opa[0];
    end
  end

  // mul: {hi, opa} is the product/multiplier pair, shifted right
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mhi_n;
  logic [WIDTH-1:0] mlo_n;

  assign msum  = {1'b0, hi} + (opa[0] ? {1'b0, opb} : '0);
  assign mhi_n = msum[WIDTH:1];
  assign mlo_n = {msum[0], opa[WIDTH-1:1]};

  // div: hi is the partial remainder, opa shifts dividend out
  // and quotient bits in; B=0 naturally yields all-ones and A
  logic [WIDTH:0]   rpart;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] q_n;

  assign rpart = {hi, opa[WIDTH-1]};
  assign ge    = rpart >= {1'b0, opb};
  assign rem_n = rpart[WIDTH-1:0] - (ge ? opb : '0);
  assign q_n   = {opa[WIDTH-2:0], ge};

  logic [WIDTH-1:0] res_f;
  logic             res_v;
  logic             res_c;
  logic             fin;
  logic [3:0]       res_st;

  always_comb begin
    res_f = lf;
    res_v = lv;
    res_c = lc;
    fin   = 1'b0;
    unique case (state)
      S_IDLE: begin
        fin = bus.start && !go_shift && !go_mul && !go_div;
      end
      S_SHIFT: begin
        res_f = sh_n;
        res_v = 1'b0;
        res_c = sh_out;
        fin   = cnt == CW'(1);
      end
      S_MUL: begin
        res_f = mlo_n;
        res_v = |mhi_n;
        res_c = |mhi_n;
        fin   = cnt == CW'(1);
      end
      S_DIV: begin
        res_f = (fs_q == FS_REMU) ? rem_n : q_n;
        res_v = opb == '0;
        res_c = 1'b0;
        fin   = cnt == CW'(1);
      end
      default: fin = 1'b0;
    endcase
    res_st       = '0;
    res_st[ST_V] = res_v;
    res_st[ST_C] = res_c;
    res_st[ST_N] = res_f[WIDTH-1];
    res_st[ST_Z] = res_f == '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      fs_q   <= '0;
      opa    <= '0;
      opb    <= '0;
      hi     <= '0;
      cnt    <= '0;
      f_q    <= '0;
      st_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            fs_q <= bus.FS;
            opa  <= bus.A;
            opb  <= bus.B;
            hi   <= '0;
            if (go_shift) begin
              state  <= S_SHIFT;
              cnt    <= CW'(amt);
              busy_q <= 1'b1;
            end else if (go_mul || go_div) begin
              state  <= go_mul ? S_MUL : S_DIV;
              cnt    <= CW'(WIDTH);
              busy_q <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          opa <= sh_n;
          cnt <= cnt - CW'(1);
        end
        S_MUL: begin
          opa <= mlo_n;
          hi  <= mhi_n;
          cnt <= cnt - CW'(1);
        end
        S_DIV: begin
          opa <= q_n;
          hi  <= rem_n;
          cnt <= cnt - CW'(1);
        end
        default: state <= S_IDLE;
      endcase
      if (fin) begin
        f_q    <= res_f;
        st_q   <= res_st;
        done_q <= 1'b1;
        busy_q <= 1'b0;
        state  <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table, hand-written corner sequences and
// random ops checked against an arithmetic reference model.
module tb_alu_seq;
  import alu_defs::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_seq_if #(.WIDTH(16)) bus();

  alu_seq #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  fs;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] f;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  logic [4:0] codes[16] = '{
    5'h00, 5'h01, 5'h02, 5'h05, 5'h06, 5'h08, 5'h09, 5'h0A,
    5'h0B, 5'h0C, 5'h10, 5'h11, 5'h12, 5'h18, 5'h19, 5'h1A
  };

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on the operation's meaning
  function automatic void model(input logic [4:0] fs,
                                input logic [15:0] a,
                                input logic [15:0] b,
                                output logic [15:0] f,
                                output logic [3:0] st,
                                output int lat);
    int sa;
    int sb;
    int ss;
    int n;
    logic [31:0] p;
    logic v;
    logic c;
    v = 1'b0;
    c = 1'b0;
    f = '0;
    lat = 1;
    n = int'(b[3:0]);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (fs)
      5'h00: f = a;
      5'h01: begin
        f = a + 16'd1;
        c = a == 16'hFFFF;
        v = a == 16'h7FFF;
      end
      5'h02: begin
        p = 32'(a) + 32'(b);
        f = p[15:0];
        c = p[16];
        ss = sa + sb;
        v = (ss > 32767) || (ss < -32768);
      end
      5'h05: begin
        f = a - b;
        c = a >= b;
        ss = sa - sb;
        v = (ss > 32767) || (ss < -32768);
      end
      5'h06: begin
        f = a - 16'd1;
        c = a != 16'h0;
        v = a == 16'h8000;
      end
      5'h08: f = a & b;
      5'h09: f = a | b;
      5'h0A: f = a ^ b;
      5'h0B: f = ~a;
      5'h0C: f = b;
      5'h10: begin
        f = a << n;
        if (n > 0) begin c = a[16-n]; lat = n + 1; end
      end
      5'h11: begin
        f = a >> n;
        if (n > 0) begin c = a[n-1]; lat = n + 1; end
      end
      5'h12: begin
        f = 16'($signed(a) >>> n);
        if (n > 0) begin c = a[n-1]; lat = n + 1; end
      end
      5'h18: begin
        p = 32'(a) * 32'(b);
        f = p[15:0];
        v = |p[31:16];
        c = v;
        lat = 17;
      end
      5'h19: begin
        lat = 17;
        if (b == 0) begin f = 16'hFFFF; v = 1'b1; end
        else f = a / b;
      end
      5'h1A: begin
        lat = 17;
        if (b == 0) begin f = a; v = 1'b1; end
        else f = a % b;
      end
      default: f = '0;
    endcase
    st = {v, c, f[15], f == 16'h0};
  endfunction

  // drive a request for one edge, then scramble inputs
  task automatic launch(input logic [4:0] fs,
                        input logic [15:0] a,
                        input logic [15:0] b);
    bus.start = 1'b1;
    bus.FS = fs;
    bus.A = a;
    bus.B = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.FS = 5'($urandom);
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
  endtask

  // k counts edges since the accepting edge (current point = k)
  task automatic expect_done(input string name,
                             input int k0,
                             input int lat,
                             input logic [15:0] f,
                             input logic [3:0] st);
    int k;
    bit seen;
    bit busy_bad;
    k = k0;
    seen = 1'b0;
    busy_bad = 1'b0;
    while (!seen && k <= 40) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.busy !== 1'b1) busy_bad = 1'b1;
        @(posedge clock);
        #1;
        k++;
      end
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, " latency"}, 32'(k), 32'(lat));
      check({name, " F"}, 32'(bus.F), 32'(f));
      check({name, " status"}, 32'(bus.status), 32'(st));
      check({name, " busy"}, 32'(busy_bad | bus.busy), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] mf;
    logic [3:0] mst;
    int mlat;
    logic [4:0] rfs;
    logic [15:0] ra;
    logic [15:0] rb;
    int pulses;

    bus.start = 1'b0;
    bus.FS = '0;
    bus.A = '0;
    bus.B = '0;

    tbl[0]  = '{FS_ADD,   16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 1};
    tbl[1]  = '{FS_SUB,   16'h0005, 16'h0005, 16'h0000, 4'b0101, 1};
    tbl[2]  = '{FS_SUB,   16'h0000, 16'h0001, 16'hFFFF, 4'b0010, 1};
    tbl[3]  = '{FS_SHL,   16'h8001, 16'h0004, 16'h0010, 4'b0000, 5};
    tbl[4]  = '{FS_SAR,   16'h8000, 16'h000F, 16'hFFFF, 4'b0010, 16};
    tbl[5]  = '{FS_MUL,   16'h0100, 16'h0100, 16'h0000, 4'b1101, 17};
    tbl[6]  = '{FS_MUL,   16'h0012, 16'h0034, 16'h03A8, 4'b0000, 17};
    tbl[7]  = '{FS_DIVU,  16'h0064, 16'h0007, 16'h000E, 4'b0000, 17};
    tbl[8]  = '{FS_REMU,  16'h0064, 16'h0007, 16'h0002, 4'b0000, 17};
    tbl[9]  = '{FS_DIVU,  16'h1234, 16'h0000, 16'hFFFF, 4'b1010, 17};
    tbl[10] = '{FS_REMU,  16'h1234, 16'h0000, 16'h1234, 4'b1000, 17};
    tbl[11] = '{5'h03,    16'h1234, 16'h5678, 16'h0000, 4'b0001, 1};
    tbl[12] = '{FS_SHL,   16'h1234, 16'h0010, 16'h1234, 4'b0000, 1};
    tbl[13] = '{FS_DEC,   16'h0000, 16'h0000, 16'hFFFF, 4'b0010, 1};
    tbl[14] = '{FS_INC,   16'hFFFF, 16'h0000, 16'h0000, 4'b0101, 1};

    repeat (3) @(posedge clock);
    #1;
    check("reset F", 32'(bus.F), 32'd0);
    check("reset status", 32'(bus.status), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      launch(tbl[i].fs, tbl[i].a, tbl[i].b);
      expect_done($sformatf("vec%0d", i), 1, tbl[i].lat,
                  tbl[i].f, tbl[i].st);
    end

    // start during MUL must be ignored and not queued
    launch(FS_MUL, 16'h0012, 16'h0034);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    check("mid busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.FS = FS_ADD;
    bus.A = 16'h0001;
    bus.B = 16'h0001;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    expect_done("ignore", 6, 17, 16'h03A8, 4'b0000);
    @(posedge clock);
    #1;
    check("no queued done", 32'(bus.done), 32'd0);
    check("no queued busy", 32'(bus.busy), 32'd0);

    // reset at iteration 8 aborts with no done
    launch(FS_MUL, 16'h0012, 16'h0034);
    repeat (7) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort F", 32'(bus.F), 32'd0);
    check("abort status", 32'(bus.status), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    pulses = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("abort later done", 32'(pulses), 32'd0);

    // back-to-back: new start on the done cycle
    launch(FS_SHL, 16'h0001, 16'h0002);
    expect_done("b2b first", 1, 3, 16'h0004, 4'b0000);
    launch(FS_DIVU, 16'h0064, 16'h0007);
    expect_done("b2b second", 1, 17, 16'h000E, 4'b0000);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("hold F", 32'(bus.F), 32'h000E);
    check("hold done", 32'(bus.done), 32'd0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) rfs = 5'($urandom);
      else rfs = codes[$urandom_range(0, 15)];
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 16'h0;
      model(rfs, ra, rb, mf, mst, mlat);
      launch(rfs, ra, rb);
      expect_done($sformatf("rnd%0d fs=%h a=%h b=%h", i, rfs, ra, rb),
                  1, mlat, mf, mst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
